// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and defaults for the MIPS memory-bus arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, GRANT0, GRANT1)
//   DEF_AW/DEF_DW : default address/data widths
//   bus_req_t   : one master's request bundle at the default widths
package mips_bus_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DEF_AW-1:0]   address;
    logic                read;
    logic                write;
    logic [DEF_DW/8-1:0] byteenable;
    logic [DEF_DW-1:0]   writedata;
  } bus_req_t;

endpackage

// File: rtl/bus_rr_picker.sv
// bus_rr_picker
// Combinational two-way round-robin choice.
//   req0, req1 : pending requests
//   last       : most recent winner (0 = master 0, 1 = master 1)
//   valid      : at least one request pending
//   winner     : chosen master; on a tie the one that did not win last
module bus_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
// Shares one Avalon-style slave bus between the instruction-fetch master (m0)
// and the data master (m1). One master is granted at a time, the grant is held
// until the transaction completes, and ties alternate round-robin.
//   clk, reset          : clock, synchronous active-high reset
//   m0_*, m1_*          : master request ports and waitrequest/readdata returns
//   s_*                 : slave-side bus
//   busy                : high while a master holds the grant
//   grant_count         : completed transactions, wraps silently
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW/8-1:0] s_byteenable,
  output logic [DW-1:0]   s_writedata,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  output logic            busy,
  output logic [31:0]     grant_count
);

  arb_state_t  state_q, state_d;
  logic        last_q;
  logic [31:0] grant_count_q;
  logic        m0_req, m1_req;
  logic        pick_valid, pick_winner;
  logic        xfer_done;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  bus_rr_picker u_picker (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      grant_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer_done) begin
        last_q        <= (state_q == GRANT1);
        grant_count_q <= grant_count_q + 32'd1;
      end
    end
  end

  // Slave-side mux. Strobes are masked by reset so an in-flight request never
  // reaches the slave during a reset cycle; waitrequest is held high under
  // reset too, so a master cannot mistake that cycle for a completion.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GRANT0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~reset;
        s_write        = m0_write & ~reset;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest | reset;
      end
      GRANT1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~reset;
        s_write        = m1_write & ~reset;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest | reset;
      end
      default: ;
    endcase
  end

  assign xfer_done = (s_read | s_write) & ~s_waitrequest;

  // A granted master dropping its request without completing is a protocol
  // error; fall back to IDLE without counting it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = pick_winner ? GRANT1 : GRANT0;
      GRANT0:  if (xfer_done || !m0_req) state_d = IDLE;
      GRANT1:  if (xfer_done || !m1_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign busy        = (state_q != IDLE);
  assign grant_count = grant_count_q;

  m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter
// Directed bench for mips_bus_arbiter: reset hold, single read, contention,
// stalled write, reset mid-stall and counter wrap.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        busy;
  logic [31:0] grant_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_byteenable  (m0_byteenable),
    .m0_writedata   (m0_writedata),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_byteenable  (m1_byteenable),
    .m1_writedata   (m1_writedata),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_byteenable   (s_byteenable),
    .s_writedata    (s_writedata),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .busy           (busy),
    .grant_count    (grant_count)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_address = 32'h0000_0A00; m0_read = 1'b1; m0_write = 1'b0;
    m0_byteenable = 4'hF; m0_writedata = '0;
    m1_address = 32'h0000_0B00; m1_read = 1'b1; m1_write = 1'b0;
    m1_byteenable = 4'hF; m1_writedata = '0;
    s_waitrequest = 1'b0;
    s_readdata = 32'h0;

    // Reset hold with both masters requesting
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("rst_strobes", {70'd0, s_read, s_write}, 72'd0);
      check("rst_wait", {70'd0, m1_waitrequest, m0_waitrequest}, 72'd3);
      check("rst_count", {40'd0, grant_count}, 72'd0);
      check("rst_busy", {71'd0, busy}, 72'd0);
    end

    // Single read by m0, zero stalls
    m0_read = 1'b0; m1_read = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    m0_address = 32'hBFC0_0000; m0_read = 1'b1;
    s_readdata = 32'h0000_1234;
    #1;
    check("rd_req_cycle_strobe", {71'd0, s_read}, 72'd0);
    check("rd_req_cycle_wait", {71'd0, m0_waitrequest}, 72'd1);
    next_cycle();
    check("rd_strobe", {39'd0, s_read, s_address}, {39'd0, 1'b1, 32'hBFC0_0000});
    check("rd_wait", {71'd0, m0_waitrequest}, 72'd0);
    check("rd_data", {40'd0, m0_readdata}, {40'd0, 32'h0000_1234});
    check("rd_m1_wait", {71'd0, m1_waitrequest}, 72'd1);
    next_cycle();
    m0_read = 1'b0;
    #1;
    check("rd_count", {40'd0, grant_count}, 72'd1);
    check("rd_idle", {71'd0, busy}, 72'd0);

    // Contention after a fresh reset: m0 wins the first tie, then alternate
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_address = 32'h0000_0A00; m1_address = 32'h0000_0B00;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      if (i == 8) begin
        m0_read = 1'b0; m1_read = 1'b0;
      end
      #1;
      case (i)
        1, 5:    check("cont_grant_m0", {70'd0, m1_waitrequest, m0_waitrequest}, 72'b10);
        3, 7:    check("cont_grant_m1", {70'd0, m1_waitrequest, m0_waitrequest}, 72'b01);
        default: check("cont_gap", {70'd0, m1_waitrequest, m0_waitrequest}, 72'b11);
      endcase
    end
    for (int i = 9; i <= 12; i++) next_cycle();
    check("cont_count", {40'd0, grant_count}, 72'd4);

    // Stalled write by m1 (3 stall cycles) while m0 waits
    m1_address = 32'h0000_0010; m1_write = 1'b1;
    m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b1100;
    s_waitrequest = 1'b1;
    next_cycle();
    m0_address = 32'h0000_0100; m0_read = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) s_waitrequest = 1'b0;
      #1;
      check("wr_slave_bus", {2'd0, s_read, s_write, s_byteenable, s_address, s_writedata},
            {2'd0, 1'b0, 1'b1, 4'b1100, 32'h0000_0010, 32'hDEAD_BEEF});
      check("wr_m0_wait", {71'd0, m0_waitrequest}, 72'd1);
      check("wr_m1_wait", {71'd0, m1_waitrequest}, {71'd0, (j < 3)});
      next_cycle();
    end
    m1_write = 1'b0;
    #1;
    check("wr_idle_gap", {71'd0, busy}, 72'd0);
    check("wr_count", {40'd0, grant_count}, 72'd5);

    // m0 granted next, then reset in its 2nd stall cycle
    s_waitrequest = 1'b1;
    next_cycle();
    check("stall_m0_granted", {39'd0, s_read, s_address}, {39'd0, 1'b1, 32'h0000_0100});
    check("stall_m1_wait", {71'd0, m1_waitrequest}, 72'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("rst_mid_strobes", {70'd0, s_read, s_write}, 72'd0);
    check("rst_mid_wait", {71'd0, m0_waitrequest}, 72'd1);
    check("rst_mid_count_kept", {40'd0, grant_count}, 72'd5);
    next_cycle();
    check("rst_mid_idle", {71'd0, busy}, 72'd0);
    check("rst_mid_count_clr", {40'd0, grant_count}, 72'd0);
    reset = 1'b0;
    m0_read = 1'b0;
    s_waitrequest = 1'b0;
    next_cycle();

    // Counter wrap
    force dut.grant_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.grant_count_q;
    #1;
    check("wrap_preload", {40'd0, grant_count}, {40'd0, 32'hFFFF_FFFF});
    m1_address = 32'h0000_2000; m1_read = 1'b1;
    s_readdata = 32'hCAFE_0001;
    next_cycle();
    check("wrap_m1_grant", {70'd0, m1_waitrequest, m0_waitrequest}, 72'b01);
    check("wrap_m1_data", {40'd0, m1_readdata}, {40'd0, 32'hCAFE_0001});
    next_cycle();
    m1_read = 1'b0;
    #1;
    check("wrap_count", {40'd0, grant_count}, 72'd0);
    check("wrap_idle", {71'd0, busy}, 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter that shares the single Avalon-style memory bus between the CPU's instruction-fetch port (m0) and data port (m1). It sits between `mips_cpu_bus` internals and `bus_memory`. It grants one master at a time, holds the grant until that transaction completes, and alternates grants round-robin so neither port starves. All other masters see `waitrequest` high while they wait.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (byteenable is `DW/8`)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_address`, `m1_address`  in  AW  master byte address
- `m0_read`, `m1_read`  in  1  read request, held until waitrequest low
- `m0_write`, `m1_write`  in  1  write request, held until waitrequest low
- `m0_byteenable`, `m1_byteenable`  in  DW/8  byte lanes
- `m0_writedata`, `m1_writedata`  in  DW  write data
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to master
- `m0_readdata`, `m1_readdata`  out  DW  read data, valid when own waitrequest low and read high
- `s_address`  out  AW  slave address
- `s_read`, `s_write`  out  1  slave strobes
- `s_byteenable`  out  DW/8  slave byte lanes
- `s_writedata`  out  DW  slave write data
- `s_waitrequest`  in  1  slave stall
- `s_readdata`  in  DW  slave read data
- `busy`  out  1  high in any GRANT state
- `grant_count`  out  32  completed transactions, wraps modulo 2^32

## Operation
- Request: `mX_req = mX_read | mX_write`. A master asserting both at once is illegal. A simulation assertion fires on it; RTL behaviour is undefined.
- States: IDLE, GRANT0, GRANT1. Register `last` (1 bit) holds the most recent winner.
- IDLE:
  - No request: stay in IDLE.
  - One request: go to that master's GRANT state.
  - Both request: grant `!last`.
- GRANTx:
  - Slave outputs mux from master x. `mx_waitrequest = s_waitrequest`. `mx_readdata = s_readdata`.
  - Completion is `(s_read|s_write) & !s_waitrequest`. On completion: `last <= x`, `grant_count++`, next state IDLE.
  - If master x drops its request without a completion cycle, that is a protocol error. The arbiter returns to IDLE and does not count it.
- Non-granted or IDLE:
  - `mX_waitrequest = 1`.
  - `mX_readdata = s_readdata` (don't-care).
  - Slave strobes = 0 and `s_address`/`s_writedata`/`s_byteenable` = 0 while in IDLE.
- `s_read` and `s_write` are gated combinationally by `!reset`. No slave transaction is visible in any cycle where `reset` is high.

## Timing
- Reset values: state IDLE, `last = 1` (so m0 wins the first tie), `grant_count = 0`, `busy = 0`, `s_read = s_write = 0`, both `mX_waitrequest = 1`.
- Arbitration latency: request first seen in IDLE at cycle N → slave strobe at N+1.
- Best-case transaction with zero slave stalls:
  - N request.
  - N+1 strobe and completion.
  - N+2 IDLE.
  - Next grant visible at N+3.
- Back-to-back requests from both masters alternate m0, m1, m0, … with exactly one IDLE cycle between grants.
- Slave stall of k cycles extends GRANTx by k. The grant is never revoked mid-transaction.
- Reset mid-transaction: the next edge forces IDLE. The interrupted transaction is dropped and not counted. Masters must re-issue after reset deasserts.
- `grant_count` increments on the completion edge. Wrap from 0xFFFFFFFF to 0 is silent.

## Structure
- Package `mips_bus_pkg`:
  - `arb_state_t` enum {IDLE, GRANT0, GRANT1}
  - `AW` and `DW` defaults
  - `bus_req_t` struct {address, read, write, byteenable, writedata}
- Sub-module `bus_rr_picker`: combinational two-input round-robin choice from (req0, req1, last) → (valid, winner). It is instantiated once.
- Top module holds the FSM, the `last` register, the counter and the output muxes.

## Test plan
- Reset hold: 4 cycles of `reset = 1` with both masters requesting.
  - Every cycle: `s_read = s_write = 0`, both waitrequest = 1, `grant_count = 0`.
- Single read: m0 reads 0xBFC00000 and the slave returns 0x00001234 with 0 stalls.
  - Strobe one cycle after the request.
  - `m0_readdata = 0x00001234` with `m0_waitrequest = 0` in that cycle.
  - `grant_count = 1`.
- Contention: both request continuously after reset, each transaction with 0 stalls.
  - Grant order m0, m1, m0, m1.
  - `grant_count = 4` after 12 cycles.
- Stalled write: m1 writes 0xDEADBEEF with byteenable 0b1100 to 0x00000010; the slave stalls 3 cycles while m0 requests.
  - m1 stays granted for 4 cycles and slave signals are stable throughout.
  - m0 `waitrequest = 1` the whole time; m0 is granted next.
- Reset mid-stall: assert `reset` during the 2nd stall cycle of an m0 read.
  - Strobes are 0 in the same cycle.
  - IDLE after the edge.
  - `grant_count` keeps its pre-reset value until the reset edge, then reads 0.
- Counter wrap: preload to 0xFFFFFFFF via force, then complete one transaction → `grant_count = 0`.
